// File: rtl/division_pkg.sv
// Shared types for the sequential unsigned divider.
// States and counter width helper.
package division_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } div_state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/division_unsigned_step.sv
// One radix-2 restoring division step, purely combinational.
// Shifts the next dividend bit into the partial remainder and trial-subtracts.
module division_unsigned_step #(
   parameter int g_width = 8
) (
   input  logic [g_width-1:0] partial,
   input  logic               dvd_bit,
   input  logic [g_width-1:0] divisor,
   output logic [g_width-1:0] partial_nxt,
   output logic               q_bit
);

   logic [g_width:0] shifted;
   logic [g_width:0] diff;

   assign shifted = {partial, dvd_bit};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = shifted >= {1'b0, divisor};

   // Restored value is always below 2^g_width, so the top bit drops out.
   assign partial_nxt = g_width'(q_bit ? diff : shifted);

endmodule

// File: rtl/division_unsigned_seq.sv
// Sequential unsigned restoring divider, g_width cycles per result.
// Optional DIVISION_ZERO_CHECK_EN: zero divisor completes in one cycle.
module division_unsigned_seq
   import division_pkg::*;
#(
   parameter int g_width = 8
) (
   input  logic               clk_i,
   input  logic               res_n_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [g_width-1:0] dividend_i,
   input  logic [g_width-1:0] divisor_i,
   output logic               busy_o,
   output logic               ready_o,
   output logic [g_width-1:0] quotient_o,
   output logic [g_width-1:0] remainder_o,
   output logic               div_zero_o
);

   localparam int CW = cnt_width(g_width);
   localparam logic [CW-1:0] LAST = CW'(g_width - 1);

   div_state_t state_q, state_d;

   logic [CW-1:0]      cnt_q;
   logic [g_width-1:0] part_q;
   logic [g_width-1:0] dvd_q;
   logic [g_width-1:0] dvs_q;
   logic [g_width-1:0] part_nxt;
   logic               q_bit;
   logic               load, step, done;
`ifdef DIVISION_ZERO_CHECK_EN
   logic               zero_hit;
   logic               div_zero_q;
`endif

   division_unsigned_step #(
      .g_width (g_width)
   ) u_step (
      .partial     (part_q),
      .dvd_bit     (dvd_q[g_width-1]),
      .divisor     (dvs_q),
      .partial_nxt (part_nxt),
      .q_bit       (q_bit)
   );

   assign busy_o = (state_q == S_RUN);

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      done    = 1'b0;
`ifdef DIVISION_ZERO_CHECK_EN
      zero_hit = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
`ifdef DIVISION_ZERO_CHECK_EN
               if (divisor_i == '0) begin
                  zero_hit = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_d = S_RUN;
               end
`else
               load    = 1'b1;
               state_d = S_RUN;
`endif
            end
         end
         S_RUN: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else begin
               step = 1'b1;
               if (cnt_q == LAST) begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Quotient bits shift into the dividend register as dividend bits leave.
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         cnt_q       <= '0;
         part_q      <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         ready_o     <= 1'b0;
         quotient_o  <= '0;
         remainder_o <= '0;
      end else begin
         ready_o <= 1'b0;
         if (load) begin
            dvd_q  <= dividend_i;
            dvs_q  <= divisor_i;
            part_q <= '0;
            cnt_q  <= '0;
         end
         if (step) begin
            part_q <= part_nxt;
            dvd_q  <= {dvd_q[g_width-2:0], q_bit};
            cnt_q  <= cnt_q + CW'(1);
         end
         if (done) begin
            quotient_o  <= {dvd_q[g_width-2:0], q_bit};
            remainder_o <= part_nxt;
            ready_o     <= 1'b1;
         end
`ifdef DIVISION_ZERO_CHECK_EN
         if (zero_hit) begin
            quotient_o  <= '1;
            remainder_o <= dividend_i;
            ready_o     <= 1'b1;
         end
`endif
      end
   end

`ifdef DIVISION_ZERO_CHECK_EN
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i)      div_zero_q <= 1'b0;
      else if (zero_hit) div_zero_q <= 1'b1;
      else if (done)     div_zero_q <= 1'b0;
   end

   assign div_zero_o = div_zero_q;
`else
   assign div_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_division_unsigned_seq.sv
// Bench for division_unsigned_seq at widths 8 and 16.
// Directed steps plus random sweep against an arithmetic reference.
module tb_division_unsigned_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        res_n, start8, start16, abort;
   logic [15:0] dvd, dvs;
   logic        busy8, ready8, dz8;
   logic [7:0]  q8, r8;
   logic        busy16, ready16, dz16;
   logic [15:0] q16, r16;

   int total = 0;
   int bad   = 0;

`ifdef DIVISION_ZERO_CHECK_EN
   localparam bit ZC = 1'b1;
`else
   localparam bit ZC = 1'b0;
`endif

   division_unsigned_seq #(.g_width(8)) u8 (
      .clk_i       (clk),
      .res_n_i     (res_n),
      .start_i     (start8),
      .abort_i     (abort),
      .dividend_i  (dvd[7:0]),
      .divisor_i   (dvs[7:0]),
      .busy_o      (busy8),
      .ready_o     (ready8),
      .quotient_o  (q8),
      .remainder_o (r8),
      .div_zero_o  (dz8)
   );

   division_unsigned_seq #(.g_width(16)) u16 (
      .clk_i       (clk),
      .res_n_i     (res_n),
      .start_i     (start16),
      .abort_i     (abort),
      .dividend_i  (dvd),
      .divisor_i   (dvs),
      .busy_o      (busy16),
      .ready_o     (ready16),
      .quotient_o  (q16),
      .remainder_o (r16),
      .div_zero_o  (dz16)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mask_w(input bit w16);
      return w16 ? 16'hFFFF : 16'h00FF;
   endfunction

   // Issue one start; return edges until ready and busy samples seen.
   task automatic run(input bit w16, input logic [15:0] a,
                      input logic [15:0] b, input bit ab,
                      output int lat, output int bcnt);
      dvd   = a;
      dvs   = b;
      abort = ab;
      if (w16) start16 = 1'b1;
      else     start8  = 1'b1;
      @(posedge clk); #1;
      start8  = 1'b0;
      start16 = 1'b0;
      abort   = 1'b0;
      lat  = 0;
      bcnt = 0;
      while (!(w16 ? ready16 : ready8) && lat < 64) begin
         if (w16 ? busy16 : busy8) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic div_chk(input string tag, input bit w16,
                          input logic [15:0] a, input logic [15:0] b,
                          input bit ab);
      int lat, bcnt, w;
      logic [15:0] m, eq, er;
      bit zero;
      w    = w16 ? 16 : 8;
      m    = mask_w(w16);
      a    = a & m;
      b    = b & m;
      zero = (b == 16'd0);
      eq   = zero ? m : a / b;
      er   = zero ? a : a % b;
      run(w16, a, b, ab, lat, bcnt);
      chk({tag, ".lat"},  lat,  (zero && ZC) ? 0 : w);
      chk({tag, ".busy"}, bcnt, (zero && ZC) ? 0 : w);
      chk({tag, ".q"}, w16 ? q16 : {8'd0, q8}, eq);
      chk({tag, ".r"}, w16 ? r16 : {8'd0, r8}, er);
      chk({tag, ".dz"}, w16 ? dz16 : dz8, zero && ZC);
   endtask

   initial begin
      int lat, bcnt, n;
      time t1, t2;
      logic [15:0] a, b;
      bit w16;

      res_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
      abort = 1'b0; dvd = '0; dvs = '0;
      #12;
      chk("reset8", {busy8, ready8, dz8, q8, r8}, 0);
      chk("reset16", {busy16, ready16, dz16, q16, r16}, 0);
      @(negedge clk) res_n = 1'b1;
      @(posedge clk); #1;

      div_chk("d100_7", 1'b0, 16'd100, 16'd7, 1'b0);
      @(posedge clk); #1;
      chk("pulse", ready8, 1'b0);

      div_chk("d255_1", 1'b0, 16'd255, 16'd1, 1'b0);
      t1 = $time;
      div_chk("d3_255", 1'b0, 16'd3, 16'd255, 1'b0);
      t2 = $time;
      chk("b2b_gap", 32'((t2 - t1) / 10), 9);

      div_chk("d42_0", 1'b0, 16'd42, 16'd0, 1'b0);
      div_chk("d77_5_ab", 1'b0, 16'd77, 16'd5, 1'b1);

      // Second start while busy must not disturb the running division.
      dvd = 16'd50; dvs = 16'd6; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      dvd = 16'd9; dvs = 16'd2; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      n = 0;
      while (!ready8 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ign.n", n, 4);
      chk("ign.q", q8, 8);
      chk("ign.r", r8, 2);
      @(posedge clk); #1;
      chk("ign.idle", busy8, 1'b0);

      dvd = 16'd200; dvs = 16'd3; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort.busy", busy8, 1'b0);
      n = 0;
      repeat (12) begin
         if (ready8) n++;
         @(posedge clk); #1;
      end
      chk("abort.rdy", n, 0);
      chk("abort.q", q8, 8);
      chk("abort.r", r8, 2);

      dvd = 16'd100; dvs = 16'd7; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      res_n = 1'b0;
      #1;
      chk("midrst", {busy8, ready8, dz8, q8, r8}, 0);
      @(negedge clk) res_n = 1'b1;
      @(posedge clk); #1;
      div_chk("post_rst", 1'b0, 16'd100, 16'd7, 1'b0);

      div_chk("w16_max", 1'b1, 16'hFFFF, 16'd255, 1'b0);
      div_chk("w16_zero", 1'b1, 16'd1234, 16'd0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         w16 = i[0];
         a = 16'($urandom);
         b = 16'($urandom) >> $urandom_range(0, w16 ? 15 : 7);
         if ($urandom_range(0, 7) == 0) b = 16'd0;
         div_chk($sformatf("rnd%0d", i), w16, a, b, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
